serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/full_adder.sv | 14 +
 rtl/serial_adder.sv | 74 +++++++
 tb/tb_serial_adder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: default operand width and counter sizing.
// Pure declarations; no latency or flow control involved.
package serial_adder_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int WIDTH_MIN     = 2;
    localparam int WIDTH_MAX     = 32;

    // Counter must represent 0..width inclusive, hence the +1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder for the serial datapath; purely combinational, zero latency.
// No flow control: outputs follow inputs within the cycle.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first: result final WIDTH enabled cycles after the load edge.
// enable low stalls every register; pload restarts, rst overrides both.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pload,
    input  logic             enable,
    input  logic [WIDTH-1:0] adata,
    input  logic [WIDTH-1:0] bdata,
    output logic [WIDTH-1:0] pout,
    output logic             cout,
    output logic             done
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(WIDTH);

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    count;
    logic             done_r;

    logic             sum_bit;
    logic             carry_nxt;
    logic             advance;

    full_adder u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .s   (sum_bit),
        .co  (carry_nxt)
    );

    // Once count saturates at WIDTH, further enables are ignored so the result holds.
    assign advance = enable && (count < CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
            done_r <= 1'b0;
        end else if (pload) begin
            a_sr   <= adata;
            b_sr   <= bdata;
            res_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
            done_r <= 1'b0;
        end else if (advance) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr <= {sum_bit, res_sr[WIDTH-1:1]};
            carry  <= carry_nxt;
            count  <= count + CW'(1);
            done_r <= (count == CNT_LAST);
        end
    end

    assign pout = res_sr;
    assign cout = carry;
    assign done = done_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: scoreboard of expected sums per load.
// Inputs change #1 after the rising edge; outputs are sampled at that same point.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         pload;
    logic         enable;
    logic [W-1:0] adata;
    logic [W-1:0] bdata;
    logic [W-1:0] pout;
    logic         cout;
    logic         done;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0] p;
        logic         c;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .pload  (pload),
        .enable (enable),
        .adata  (adata),
        .bdata  (bdata),
        .pout   (pout),
        .cout   (cout),
        .done   (done)
    );

    task automatic tick(input logic r, input logic pl, input logic en,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        rst    = r;
        pload  = pl;
        enable = en;
        adata  = a;
        bdata  = b;
        @(posedge clk);
        #1;
    endtask

    // Starting a load aborts whatever was outstanding, so the scoreboard is reset too.
    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input logic en);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        sb.delete();
        sb.push_back('{p: s[W-1:0], c: s[W]});
        tick(1'b0, 1'b1, en, a, b);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 1'b0, '0, '0);
        tick(1'b1, 1'b1, 1'b1, 8'hA5, 8'h5A);
        sb.delete();
        checks++;
        if (pout !== 8'h00) begin failures++; $display("FAIL reset_pout: got %h want 00", pout); end
        checks++;
        if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout: got %b want 0", cout); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_zero_after_reset();
        for (int i = 0; i < W - 1; i++) tick(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF);
        checks++;
        if (done !== 1'b0 || pout !== 8'h00) begin
            failures++; $display("FAIL zero_early: got done=%b pout=%h want done=0 pout=00", done, pout);
        end
        tick(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF);
        checks++;
        if (done !== 1'b1 || pout !== 8'h00 || cout !== 1'b0) begin
            failures++;
            $display("FAIL zero_done: got done=%b pout=%h cout=%b want 1/00/0", done, pout, cout);
        end
    endtask

    task automatic test_add(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        exp_t e;
        bit   early;
        early = 1'b0;
        tick(1'b1, 1'b0, 1'b0, '0, '0);
        load(a, b, 1'b0);
        for (int i = 0; i < W; i++) begin
            tick(1'b0, 1'b0, 1'b1, '0, '0);
            if (i < W - 1 && done) early = 1'b1;
        end
        checks++;
        if (early) begin failures++; $display("FAIL %s_done_early: got done=1 want 0 before edge %0d", name, W); end
        checks++;
        if (sb.size() == 0) begin
            failures++; $display("FAIL %s_sb: got empty scoreboard want 1 entry", name);
        end else begin
            e = sb.pop_front();
            if (pout !== e.p || cout !== e.c || done !== 1'b1) begin
                failures++;
                $display("FAIL %s_result: got pout=%h cout=%b done=%b want %h/%b/1", name, pout, cout, done, e.p, e.c);
            end
        end
    endtask

    task automatic test_gaps_and_hold();
        logic [W:0] s;
        exp_t       e;
        bit         bad;
        s = 9'h03C + 9'h00F;
        load(8'h3C, 8'h0F, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, '0, '0);
        checks++;
        if (pout[W-1:W-3] !== s[2:0]) begin
            failures++; $display("FAIL gaps_partial: got %b want %b", pout[W-1:W-3], s[2:0]);
        end
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF);
            if (done !== 1'b0 || pout[W-1:W-3] !== s[2:0] || pout[W-4:0] !== '0) bad = 1'b1;
        end
        checks++;
        if (bad) begin failures++; $display("FAIL gaps_stall: got pout=%h done=%b want frozen partial", pout, done); end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 1'b1, '0, '0);
            if ((i < 4 && done !== 1'b0) || (i == 4 && done !== 1'b1)) bad = 1'b1;
        end
        checks++;
        if (bad) begin failures++; $display("FAIL gaps_done_timing: got done=%b want rise on 8th enabled edge", done); end
        checks++;
        if (sb.size() == 0) begin
            failures++; $display("FAIL gaps_sb: got empty scoreboard want 1 entry");
            e = '{p: s[W-1:0], c: s[W]};
        end else begin
            e = sb.pop_front();
            if (pout !== e.p || cout !== e.c || e.p !== 8'h4B) begin
                failures++; $display("FAIL gaps_result: got pout=%h cout=%b want 4b/0", pout, cout);
            end
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b1, 8'h11, 8'h22);
            if (pout !== e.p || cout !== e.c || done !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL hold_after_done: got pout=%h cout=%b done=%b want %h/%b/1", pout, cout, done, e.p, e.c);
        end
    endtask

    task automatic test_reset_mid();
        load(8'hFF, 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, '0, '0);
        tick(1'b1, 1'b1, 1'b1, 8'h77, 8'h77);
        sb.delete();
        checks++;
        if (pout !== 8'h00 || cout !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_mid: got pout=%h cout=%b done=%b want 00/0/0", pout, cout, done);
        end
    endtask

    task automatic test_reload_mid();
        exp_t e;
        load(8'h12, 8'h34, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1, '0, '0);
        load(8'h80, 8'h80, 1'b1);
        checks++;
        if (pout !== 8'h00 || cout !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reload_restart: got pout=%h cout=%b done=%b want 00/0/0", pout, cout, done);
        end
        for (int i = 0; i < W; i++) tick(1'b0, 1'b0, 1'b1, '0, '0);
        checks++;
        if (sb.size() == 0) begin
            failures++; $display("FAIL reload_sb: got empty scoreboard want 1 entry");
        end else begin
            e = sb.pop_front();
            if (pout !== e.p || cout !== e.c || done !== 1'b1) begin
                failures++; $display("FAIL reload_result: got pout=%h cout=%b done=%b want %h/%b/1", pout, cout, done, e.p, e.c);
            end
        end
    endtask

    task automatic test_random();
        exp_t        e;
        logic [W-1:0] a, b;
        int          nen;
        int          budget;
        bit          bad;
        for (int op = 0; op < 6; op++) begin
            a = W'($urandom);
            b = W'($urandom);
            load(a, b, 1'b0);
            nen    = 0;
            budget = 0;
            bad    = 1'b0;
            while (nen < W && budget < 60) begin
                logic en;
                en = ($urandom_range(0, 2) != 0);
                tick(1'b0, 1'b0, en, W'($urandom), W'($urandom));
                if (en) nen++;
                budget++;
                if (nen < W && done !== 1'b0) bad = 1'b1;
            end
            checks++;
            if (bad || nen < W) begin
                failures++; $display("FAIL random_timing op%0d: got enabled=%0d done=%b want done only after %0d", op, nen, done, W);
            end
            checks++;
            if (sb.size() == 0) begin
                failures++; $display("FAIL random_sb op%0d: got empty scoreboard want 1 entry", op);
            end else begin
                e = sb.pop_front();
                if (pout !== e.p || cout !== e.c || done !== 1'b1) begin
                    failures++;
                    $display("FAIL random_result op%0d a=%h b=%h: got pout=%h cout=%b done=%b want %h/%b/1",
                             op, a, b, pout, cout, done, e.p, e.c);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_after_reset();
        test_add(8'hAA, 8'h55, "aa55");
        test_add(8'hFF, 8'h01, "ff01");
        test_gaps_and_hold();
        test_reset_mid();
        test_reload_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
